// File: rtl/jericalla_fetch_unit_if.sv
// Bundle of the sequencer's control, program-load and instruction-out signals.
// The master side drives control and program writes; the slave is the fetch unit.
interface jericalla_fetch_unit_if #(
  parameter int AW = 5,
  parameter int IW = 19
);
  logic          start;
  logic          stall;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic [7:0]    issued;

  modport master (
    output start, stall, prog_we, prog_addr, prog_data,
    input  instruction, instr_valid, pc, busy, done, issued
  );

  modport slave (
    input  start, stall, prog_we, prog_addr, prog_data,
    output instruction, instr_valid, pc, busy, done, issued
  );
endinterface

// File: rtl/jericalla_fetch_unit.sv
// Self-running instruction sequencer: walks a writable program memory, holding
// each word valid for HOLD cycles (stretched by stall) until HALT or end of memory.
module jericalla_fetch_unit #(
  parameter int          DEPTH   = 32,
  parameter int          AW      = 5,
  parameter int          IW      = 19,
  parameter int          HOLD    = 3,
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic                    clk,
  input  logic                    reset,
  jericalla_fetch_unit_if.slave   bus
);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] rdata;
  logic [IW-1:0] ir, ir_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    issued, issued_nxt;
  logic          valid, valid_nxt;
  logic          busy, busy_nxt;
  logic          done, done_nxt;
  logic          prog_ok;

  // Program memory is never reset; loads are only accepted while not running.
  assign prog_ok = bus.prog_we && (state == IDLE || state == DONE);

  always_ff @(posedge clk)
    if (prog_ok) mem[bus.prog_addr] <= bus.prog_data;

  assign rdata = mem[pc];

  always_comb begin
    state_nxt  = state;
    ir_nxt     = ir;
    pc_nxt     = pc;
    cnt_nxt    = cnt;
    issued_nxt = issued;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          pc_nxt     = '0;
          issued_nxt = '0;
          state_nxt  = FETCH;
        end
      end
      FETCH: begin
        // A HALT word ends the run without ever reaching the datapath.
        if (rdata[IW-1 -: 4] == HALT_OP) begin
          state_nxt = DONE;
        end else begin
          ir_nxt     = rdata;
          cnt_nxt    = CW'(HOLD - 1);
          issued_nxt = (issued == 8'hFF) ? issued : issued + 8'd1;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        if (!bus.stall) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CW'(1);
          end else begin
            ir_nxt = '0;
            if (pc == LAST) begin
              state_nxt = DONE;
            end else begin
              pc_nxt    = pc + AW'(1);
              state_nxt = FETCH;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Status flags are registered from the next state so outputs stay glitch-free.
    valid_nxt = (state_nxt == EXEC);
    busy_nxt  = (state_nxt == FETCH) || (state_nxt == EXEC);
    done_nxt  = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ir     <= '0;
      pc     <= '0;
      cnt    <= '0;
      issued <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ir     <= ir_nxt;
      pc     <= pc_nxt;
      cnt    <= cnt_nxt;
      issued <= issued_nxt;
      valid  <= valid_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  assign bus.instruction = ir;
  assign bus.instr_valid = valid;
  assign bus.pc          = pc;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.issued      = issued;
endmodule

// File: tb/tb_jericalla_fetch_unit.sv
// Directed bench for jericalla_fetch_unit: cycle table for the basic program
// plus hand-written stall, write-protect, reset and end-of-memory sequences.
module tb_jericalla_fetch_unit;
  localparam logic [18:0] W0   = 19'b0010001000000000001;
  localparam logic [18:0] W1   = 19'b0011001010000100010;
  localparam logic [18:0] W2   = 19'b0100001100001000011;
  localparam logic [18:0] HALT = 19'b1111000000000000000;
  localparam logic [18:0] WNEW = 19'b0101000110001100111;

  logic clk, reset;
  int   errors = 0;
  int   checks = 0;

  jericalla_fetch_unit_if #(.AW(5), .IW(19)) bus ();

  jericalla_fetch_unit #(.DEPTH(32), .AW(5), .IW(19), .HOLD(3), .HALT_OP(4'b1111)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stall;
    logic        vld;
    logic [18:0] ins;
    logic [4:0]  pc;
    logic        busy;
    logic        done;
    logic [7:0]  iss;
  } vec_t;

  vec_t        tbl [15];
  int          len [32];
  logic [18:0] word [32];
  logic [4:0]  fin_pc;
  logic [7:0]  fin_iss;
  logic        fin_done;

  function automatic vec_t mk(logic st, logic sl, logic v, logic [18:0] i,
                              logic [4:0] p, logic b, logic d, logic [7:0] n);
    vec_t r;
    r.start = st; r.stall = sl; r.vld = v; r.ins = i;
    r.pc = p; r.busy = b; r.done = d; r.iss = n;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [4:0] a, input logic [18:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
    tick();
    bus.prog_we = 1'b0;
  endtask

  task automatic load_basic();
    write_word(5'd0, W0);
    write_word(5'd1, W1);
    write_word(5'd2, W2);
    write_word(5'd3, HALT);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 15; i++) begin
      bus.start = tbl[i].start;
      bus.stall = tbl[i].stall;
      tick();
      chk($sformatf("%s[%0d].valid", tag, i), 32'(bus.instr_valid), 32'(tbl[i].vld));
      chk($sformatf("%s[%0d].instr", tag, i), 32'(bus.instruction), 32'(tbl[i].ins));
      chk($sformatf("%s[%0d].pc", tag, i), 32'(bus.pc), 32'(tbl[i].pc));
      chk($sformatf("%s[%0d].busy", tag, i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("%s[%0d].done", tag, i), 32'(bus.done), 32'(tbl[i].done));
      chk($sformatf("%s[%0d].issued", tag, i), 32'(bus.issued), 32'(tbl[i].iss));
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
  endtask

  // Starts a run and records, per address, how many cycles its word was valid.
  task automatic run(input string tag, input int sp, input int sn,
                     input bit wr_en, input logic [4:0] wa, input logic [18:0] wd);
    int ns;
    bit wdone, hit;
    ns = 0; wdone = 0; hit = 0;
    for (int i = 0; i < 32; i++) begin len[i] = 0; word[i] = '0; end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      bus.prog_we = 1'b0;
      if (bus.done) begin hit = 1; break; end
      if (bus.instr_valid) begin
        len[bus.pc]++;
        word[bus.pc] = bus.instruction;
      end
      bus.stall = bus.instr_valid && (int'(bus.pc) == sp) && (ns < sn);
      if (bus.stall) ns++;
      if (wr_en && !wdone && bus.instr_valid && bus.pc == 5'd0) begin
        bus.prog_we = 1'b1; bus.prog_addr = wa; bus.prog_data = wd;
        wdone = 1;
      end
    end
    bus.stall = 1'b0;
    bus.prog_we = 1'b0;
    fin_pc = bus.pc; fin_iss = bus.issued; fin_done = bus.done;
    if (!hit) begin
      checks++; errors++;
      $display("FAIL %s.timeout: done never rose within 400 cycles", tag);
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 19'd0, 5'd0, 1, 0, 8'd0);
    tbl[1]  = mk(0, 0, 1, W0,    5'd0, 1, 0, 8'd1);
    tbl[2]  = mk(0, 0, 1, W0,    5'd0, 1, 0, 8'd1);
    tbl[3]  = mk(0, 0, 1, W0,    5'd0, 1, 0, 8'd1);
    tbl[4]  = mk(0, 0, 0, 19'd0, 5'd1, 1, 0, 8'd1);
    tbl[5]  = mk(0, 0, 1, W1,    5'd1, 1, 0, 8'd2);
    tbl[6]  = mk(0, 0, 1, W1,    5'd1, 1, 0, 8'd2);
    tbl[7]  = mk(0, 0, 1, W1,    5'd1, 1, 0, 8'd2);
    tbl[8]  = mk(0, 0, 0, 19'd0, 5'd2, 1, 0, 8'd2);
    tbl[9]  = mk(0, 0, 1, W2,    5'd2, 1, 0, 8'd3);
    tbl[10] = mk(0, 0, 1, W2,    5'd2, 1, 0, 8'd3);
    tbl[11] = mk(0, 0, 1, W2,    5'd2, 1, 0, 8'd3);
    tbl[12] = mk(0, 0, 0, 19'd0, 5'd3, 1, 0, 8'd3);
    tbl[13] = mk(0, 0, 0, 19'd0, 5'd3, 0, 1, 8'd3);
    tbl[14] = mk(0, 0, 0, 19'd0, 5'd3, 0, 1, 8'd3);

    bus.start = 0; bus.stall = 0; bus.prog_we = 0; bus.prog_addr = '0; bus.prog_data = '0;
    reset = 1'b0;
    #3;
    chk("rst.valid", 32'(bus.instr_valid), 32'd0);
    chk("rst.instr", 32'(bus.instruction), 32'd0);
    chk("rst.pc", 32'(bus.pc), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.issued", 32'(bus.issued), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    load_basic();
    run_table("basic");
    run_table("restart");

    // Four stalled edges during addr1 stretch it from 3 to 7 valid cycles.
    run("stall", 1, 4, 0, 5'd0, 19'd0);
    chk("stall.len0", 32'(len[0]), 32'd3);
    chk("stall.len1", 32'(len[1]), 32'd7);
    chk("stall.len2", 32'(len[2]), 32'd3);
    chk("stall.len3", 32'(len[3]), 32'd0);
    chk("stall.word1", 32'(word[1]), 32'(W1));
    chk("stall.issued", 32'(fin_iss), 32'd3);
    chk("stall.pc", 32'(fin_pc), 32'd3);

    run("wprot", -1, 0, 1, 5'd2, WNEW);
    chk("wprot.word2_busy", 32'(word[2]), 32'(W2));
    chk("wprot.len2", 32'(len[2]), 32'd3);
    write_word(5'd2, WNEW);
    run("wdone", -1, 0, 0, 5'd0, 19'd0);
    chk("wdone.word2", 32'(word[2]), 32'(WNEW));
    chk("wdone.issued", 32'(fin_iss), 32'd3);
    write_word(5'd2, W2);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 20 && !(bus.instr_valid && bus.pc == 5'd1); c++) tick();
    chk("midrst.reached_pc1", 32'(bus.instr_valid && bus.pc == 5'd1), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst.valid", 32'(bus.instr_valid), 32'd0);
    chk("midrst.instr", 32'(bus.instruction), 32'd0);
    chk("midrst.pc", 32'(bus.pc), 32'd0);
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.issued", 32'(bus.issued), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("midrst.idle_busy", 32'(bus.busy), 32'd0);
    run("rerun", -1, 0, 0, 5'd0, 19'd0);
    chk("rerun.word0", 32'(word[0]), 32'(W0));
    chk("rerun.word1", 32'(word[1]), 32'(W1));
    chk("rerun.word2", 32'(word[2]), 32'(W2));
    chk("rerun.issued", 32'(fin_iss), 32'd3);

    for (int i = 0; i < 32; i++) begin
      logic [4:0] a;
      a = i[4:0];
      write_word(a, {4'b0001, a, 10'h0});
    end
    run("eom", -1, 0, 0, 5'd0, 19'd0);
    begin
      int full;
      full = 0;
      for (int i = 0; i < 32; i++) if (len[i] == 3) full++;
      chk("eom.words_full", 32'(full), 32'd32);
    end
    chk("eom.word31", 32'(word[31]), 32'({4'b0001, 5'd31, 10'h0}));
    chk("eom.issued", 32'(fin_iss), 32'd32);
    chk("eom.pc", 32'(fin_pc), 32'd31);
    chk("eom.done", 32'(fin_done), 32'd1);
    tick();
    tick();
    chk("eom.nowrap_pc", 32'(bus.pc), 32'd31);
    chk("eom.nowrap_valid", 32'(bus.instr_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
